avalon_input_pio: RTL and testbench
===================================

AVALON_INPUT_PIO -- requirements
Module: avalon_input_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of input channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable-cycle count before a debounced bit changes (1 ms at 50 MHz).
REQ-003 SHALL have parameter RESET_LEVEL, default all-ones, WIDTH-bit reset value of the synchroniser and debounced state (idle-high buttons).
REQ-004 SHALL have ports in this order:
- clk_clk  input  1  sole clock.
- reset_reset  input  1  asynchronous, active-high reset.
- pio_in  input  WIDTH  raw asynchronous switch/button lines.
- avs_address  input  2  word address.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data.
- irq  output  1  level interrupt.

Function
REQ-005 SHALL pass each pio_in bit through a 2-flop synchroniser.
REQ-006 SHALL debounce each channel independently with a counter of width clog2(DEBOUNCE_CYCLES+1).
- Counter clears when synchronised value equals debounced value.
- Counter increments while they differ.
- When the count reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced bit SHALL take the synchronised value and the counter SHALL clear.
REQ-007 SHALL expose this register map; bits above WIDTH-1 read 0:
- 0 DATA: debounced state, read-only.
- 1 IRQ_MASK: read/write.
- 2 EDGE_CAPTURE: read; write-1-to-clear per bit.
- 3 EDGE_SEL: read/write, 1 = rising, 0 = falling.
REQ-008 SHALL set EDGE_CAPTURE[i] in the cycle after debounced[i] makes the transition selected by EDGE_SEL[i]; a captured bit SHALL stay set until cleared.
REQ-009 SHALL set a captured bit when a set event and a write-1-to-clear of that bit occur in the same cycle (set wins).
REQ-010 SHALL drive avs_readdata one cycle after avs_read (fixed read latency 1); avs_readdata SHALL hold its last value when no read is in progress.
REQ-011 SHALL ignore writes to address 0.
REQ-012 SHALL take writes effect in the cycle after avs_write.
REQ-013 SHALL register irq as the OR of (EDGE_CAPTURE AND IRQ_MASK), one cycle after either operand changes.
REQ-014 SHALL complete a simultaneous avs_read and avs_write at the same address as the read of the pre-write value.
REQ-015 SHALL NOT set the capture bit when EDGE_SEL[i] changes, even if the debounced level matches the new polarity; only debounced transitions capture.

Reset
REQ-016 SHALL, on reset_reset assertion, asynchronously clear the following, with no edge captured due to reset:
- synchroniser and debounced state to RESET_LEVEL;
- counters, IRQ_MASK, EDGE_CAPTURE and EDGE_SEL to 0;
- avs_readdata and irq to 0.
REQ-017 SHALL deassert reset synchronously from the system level; the block SHALL NOT resynchronise it.
REQ-018 SHALL abandon an in-flight debounce count on reset assertion mid-count.

Configuration
REQ-019 SHALL, with macro PIO_DEBOUNCE_EN defined, include the debounce counters per REQ-006.
REQ-020 SHALL, with PIO_DEBOUNCE_EN undefined, drive the debounced state directly from the synchroniser output (latency 2 cycles) and instantiate no counters; DEBOUNCE_CYCLES SHALL be ignored.

Structure
REQ-021 SHALL place register address localparams (ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_SEL=3) in the shared package avalon_pio_pkg.
REQ-022 SHALL implement synchroniser plus debounce for a single channel as the sub-module pio_debounce, generated WIDTH times.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, PIO_DEBOUNCE_EN defined unless stated)
REQ-023 Reset with pio_in=4'hF -> DATA reads 0xF, EDGE_CAPTURE reads 0, irq=0.
REQ-024 pio_in[0] 1->0 held 10 cycles, EDGE_SEL=0, IRQ_MASK=1 -> DATA=0xE after 2+4 cycles, EDGE_CAPTURE=0x1, irq=1 one cycle later.
REQ-025 pio_in[1] glitch low for 3 cycles -> DATA stays 0xF, EDGE_CAPTURE stays 0.
REQ-026 Write EDGE_CAPTURE=0x1 in the same cycle as a new falling edge on bit 0 -> bit 0 remains set, irq stays 1.
REQ-027 Write 0x1 to address 2 with no new edge -> EDGE_CAPTURE=0, irq drops the following cycle; a write to address 0 leaves DATA unchanged.
REQ-028 PIO_DEBOUNCE_EN undefined, pio_in[2] low for 1 cycle -> DATA bit 2 low exactly 2 cycles later for 1 cycle; edge captured.

Source files
------------

// File: rtl/avalon_pio_pkg.sv
// avalon_pio_pkg: register map shared by avalon_input_pio and its users
package avalon_pio_pkg;
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_EDGE = 2'd2;
   localparam logic [1:0] ADDR_SEL  = 2'd3;
endpackage

// File: rtl/pio_debounce.sv
// pio_debounce: 2-flop synchroniser plus optional debounce for one input channel
// Ports: clk, rst (async active-high), din raw async line, dout debounced level.
// Build option PIO_DEBOUNCE_EN: when undefined dout is the synchroniser output and
// DEBOUNCE_CYCLES is ignored.
module pio_debounce #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RESET_BIT       = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);
   logic s1, s2;
   always_ff @(posedge clk or posedge rst)
      if (rst) {s2, s1} <= {2{RESET_BIT}};
      else {s2, s1} <= {s1, din};
`ifdef PIO_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CW-1:0] cnt;
   // The count tallies consecutive mismatch cycles; the cycle that would be the
   // DEBOUNCE_CYCLES-th mismatch commits the new level instead of counting.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt  <= '0;
         dout <= RESET_BIT;
      end else if (s2 == dout) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         cnt  <= '0;
         dout <= s2;
      end else cnt <= cnt + 1'b1;
`else
   localparam int unused_dc = DEBOUNCE_CYCLES;
   assign dout = s2;
`endif
endmodule

// File: rtl/avalon_input_pio.sv
// avalon_input_pio: debounced input PIO with edge capture, Avalon-MM slave and level irq
// Ports: clk_clk, reset_reset (async active-high); pio_in raw lines;
//        avs_address/avs_read/avs_write/avs_writedata/avs_readdata Avalon-MM slave
//        (read latency 1); irq registered OR of edge_capture & irq_mask.
// Build option PIO_DEBOUNCE_EN: enables per-channel debounce counters.
module avalon_input_pio
   import avalon_pio_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [WIDTH-1:0] pio_in,
   input  logic [1:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             irq
);
   logic [WIDTH-1:0] deb, deb_d, irq_mask, edge_cap, edge_sel, edge_set, edge_clr, wdata;
   logic [31:0] rd_mux;
   logic unused_wdata;
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      pio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_BIT      (RESET_LEVEL[i])
      ) u_deb (
         .clk (clk_clk),
         .rst (reset_reset),
         .din (pio_in[i]),
         .dout(deb[i])
      );
   end
   assign wdata        = avs_writedata[WIDTH-1:0];
   assign unused_wdata = ^avs_writedata;
   // A transition is selected when the new debounced level equals the polarity bit,
   // so changing edge_sel alone never produces an event.
   always_comb begin
      edge_set = (deb ^ deb_d) & ~(deb ^ edge_sel);
      edge_clr = (avs_write && avs_address == ADDR_EDGE) ? wdata : '0;
      rd_mux   = avs_address == ADDR_DATA ? 32'(deb) :
                 avs_address == ADDR_MASK ? 32'(irq_mask) :
                 avs_address == ADDR_EDGE ? 32'(edge_cap) : 32'(edge_sel);
   end
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         deb_d        <= RESET_LEVEL;
         irq_mask     <= '0;
         edge_cap     <= '0;
         edge_sel     <= '0;
         avs_readdata <= '0;
         irq          <= 1'b0;
      end else begin
         deb_d    <= deb;
         edge_cap <= (edge_cap & ~edge_clr) | edge_set;
         irq      <= |(edge_cap & irq_mask);
         if (avs_write && avs_address == ADDR_MASK) irq_mask <= wdata;
         if (avs_write && avs_address == ADDR_SEL) edge_sel <= wdata;
         if (avs_read) avs_readdata <= rd_mux;
      end
endmodule

// File: tb/tb_avalon_input_pio.sv
// tb_avalon_input_pio: directed self-checking bench for avalon_input_pio (WIDTH=4, DEBOUNCE_CYCLES=4)
module tb_avalon_input_pio;
`ifdef PIO_DEBOUNCE_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 2;
`endif
   logic clk = 1'b0, rst = 1'b0, avs_read = 1'b0, avs_write = 1'b0, irq;
   logic [3:0] pio_in = 4'hF;
   logic [1:0] address = 2'd0;
   logic [31:0] writedata = '0, readdata;
   int n_assert = 0, n_fail = 0;
   always #5 clk = ~clk;
   avalon_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(4'hF)) dut (
      .clk_clk      (clk),
      .reset_reset  (rst),
      .pio_in       (pio_in),
      .avs_address  (address),
      .avs_read     (avs_read),
      .avs_write    (avs_write),
      .avs_writedata(writedata),
      .avs_readdata (readdata),
      .irq          (irq)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a;
      writedata = d;
      avs_write = 1'b1;
      tick();
      avs_write = 1'b0;
   endtask
   task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      avs_read = 1'b1;
      tick();
      avs_read = 1'b0;
      chk(tag, readdata, exp);
   endtask
   initial begin
      #2 rst = 1'b1;
      repeat (3) tick();
      chk("rst_irq", irq, 0);
      chk("rst_rdata", readdata, 0);
      rst = 1'b0;
      tick();
      rdchk("rst_data", 0, 32'hF);
      rdchk("rst_edge", 2, 0);
      rdchk("rst_mask", 1, 0);
      rdchk("rst_sel", 3, 0);
      chk("rst_irq2", irq, 0);
`ifdef PIO_DEBOUNCE_EN
      pio_in = 4'hD;
      repeat (3) tick();
      pio_in = 4'hF;
      repeat (10) tick();
      rdchk("glitch_data", 0, 32'hF);
      rdchk("glitch_edge", 2, 0);
      chk("glitch_irq", irq, 0);
`else
      pio_in = 4'hB;
      address = 0;
      avs_read = 1'b1;
      tick();
      pio_in = 4'hF;
      tick();
      chk("nodb_pre", readdata, 32'hF);
      tick();
      chk("nodb_low", readdata, 32'hB);
      tick();
      chk("nodb_post", readdata, 32'hF);
      avs_read = 1'b0;
      rdchk("nodb_edge", 2, 32'h4);
      wr(2, 32'h4);
      rdchk("nodb_edge_clr", 2, 0);
`endif
      wr(1, 32'h1);
      rdchk("mask_rb", 1, 32'h1);
      pio_in = 4'hE;
      address = 0;
      avs_read = 1'b1;
      repeat (LAT) tick();
      chk("fall_data_early", readdata, 32'hF);
      tick();
      chk("fall_data", readdata, 32'hE);
      chk("fall_irq_early", irq, 0);
      address = 2;
      tick();
      chk("fall_edge", readdata, 32'h1);
      chk("fall_irq", irq, 1);
      avs_read = 1'b0;
`ifdef PIO_DEBOUNCE_EN
      pio_in = 4'hC;
      repeat (4) tick();
      pio_in = 4'hE;
      repeat (12) tick();
      rdchk("pulse4_edge", 2, 32'h3);
      rdchk("pulse4_data", 0, 32'hE);
      wr(2, 32'h2);
      rdchk("pulse4_clr", 2, 32'h1);
`endif
      pio_in = 4'hF;
      repeat (LAT + 4) tick();
      rdchk("rise_data", 0, 32'hF);
      rdchk("rise_nocap", 2, 32'h1);
      pio_in = 4'hE;
      repeat (LAT) tick();
      wr(2, 32'h1);
      chk("setwin_irq0", irq, 1);
      tick();
      chk("setwin_irq1", irq, 1);
      rdchk("setwin_edge", 2, 32'h1);
      wr(2, 32'h1);
      chk("clr_irq_hold", irq, 1);
      tick();
      chk("clr_irq_drop", irq, 0);
      rdchk("clr_edge", 2, 0);
      wr(0, 32'h0);
      rdchk("wr0_data", 0, 32'hE);
      rdchk("wr0_mask", 1, 32'h1);
      chk("wr0_irq", irq, 0);
      wr(3, 32'h1);
      repeat (4) tick();
      rdchk("sel_nocap", 2, 0);
      rdchk("sel_rb", 3, 32'h1);
      chk("sel_irq", irq, 0);
      pio_in = 4'hF;
      repeat (LAT + 3) tick();
      rdchk("rise_cap", 2, 32'h1);
      chk("rise_irq", irq, 1);
      address = 1;
      writedata = 32'hA;
      avs_read = 1'b1;
      avs_write = 1'b1;
      tick();
      avs_read = 1'b0;
      avs_write = 1'b0;
      chk("rw_old", readdata, 32'h1);
      chk("rw_irq_lag", irq, 1);
      tick();
      chk("rw_irq_drop", irq, 0);
      chk("rd_hold", readdata, 32'h1);
      rdchk("rw_new", 1, 32'hA);
      wr(1, 32'hFFFF_FFF5);
      rdchk("upper_zero", 1, 32'h5);
      wr(1, 32'h1);
      tick();
      chk("remask_irq", irq, 1);
      pio_in = 4'hE;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      chk("async_irq", irq, 0);
      chk("async_rdata", readdata, 0);
      pio_in = 4'hF;
      tick();
      rst = 1'b0;
      tick();
      rdchk("rst2_data", 0, 32'hF);
      rdchk("rst2_edge", 2, 0);
      rdchk("rst2_mask", 1, 0);
      rdchk("rst2_sel", 3, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
